// File: rtl/pmu_counter_bank.sv
// Parametrised bank of per-tile, per-event performance counters with run/stop control,
// wrap/saturate mode, sticky overflow flags, atomic snapshot and a register req/rsp port.
module pmu_counter_bank #(
    parameter int unsigned NUM_TILES  = 4,
    parameter int unsigned NUM_EVENTS = 23,
    parameter int unsigned CNT_W      = 64,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_TILES*NUM_EVENTS-1:0] event_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_we_i,
    input  logic [ADDR_W-1:0]              req_addr_i,
    input  logic [63:0]                    req_wdata_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [63:0]                    rsp_data_o,
    output logic                           rsp_err_o,
    output logic                           any_ovf_o
);
    localparam int unsigned NUM_CNT   = NUM_TILES * NUM_EVENTS;
    localparam int unsigned NUM_OVF_W = (NUM_CNT + 63) / 64;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]       cnt    [NUM_CNT];
    logic [CNT_W-1:0]       shadow [NUM_CNT];
    logic [NUM_CNT-1:0]     ovf;
    logic                   ctrl_en, ctrl_sat, ctrl_snap_rd;

    logic                   accept, wr, is_ctrl;
    logic [31:0]            word;
    logic                   cnt_hit, ctrl_hit, ovf_hit;
    logic                   clr_pulse, snap_pulse;
    logic [NUM_OVF_W*64-1:0] ovf_pad, w1c_pad;
    logic [NUM_CNT-1:0]     preset, ovf_set;
    logic [CNT_W-1:0]       cnt_rd;
    logic [63:0]            rd_data;

    assign req_ready_o = ~rsp_valid_o | rsp_ready_i;
    assign accept      = req_valid_i & req_ready_o;
    assign wr          = accept & req_we_i;
    assign is_ctrl     = req_addr_i[ADDR_W-1];
    assign word        = 32'(req_addr_i[ADDR_W-2:0]);
    assign cnt_hit     = !is_ctrl && (word < NUM_CNT);
    assign ctrl_hit    = is_ctrl && (word == 32'd0);
    assign ovf_hit     = is_ctrl && (word >= 32'd1) && (word <= NUM_OVF_W);
    assign clr_pulse   = wr & ctrl_hit & req_wdata_i[4];
    assign snap_pulse  = wr & ctrl_hit & req_wdata_i[3];

    // Read mux and per-counter write/overflow decode, all from pre-edge state.
    always_comb begin
        ovf_pad = '0;
        ovf_pad[NUM_CNT-1:0] = ovf;
        w1c_pad = '0;
        cnt_rd  = '0;
        rd_data = '0;
        preset  = '0;
        ovf_set = '0;
        for (int k = 0; k < int'(NUM_OVF_W); k++) begin
            if (ovf_hit && word == 32'(k + 1)) begin
                rd_data = ovf_pad[64*k +: 64];
                if (wr) w1c_pad[64*k +: 64] = req_wdata_i;
            end
        end
        for (int i = 0; i < int'(NUM_CNT); i++) begin
            if (cnt_hit && word == 32'(i)) begin
                cnt_rd    = ctrl_snap_rd ? shadow[i] : cnt[i];
                preset[i] = wr;
            end
            ovf_set[i] = ctrl_en && event_i[i] && (cnt[i] == CNT_MAX) && !preset[i];
        end
        if (cnt_hit)  rd_data = 64'(cnt_rd);
        if (ctrl_hit) rd_data = {61'b0, ctrl_snap_rd, ctrl_sat, ctrl_en};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_en      <= 1'b0;
            ctrl_sat     <= 1'b0;
            ctrl_snap_rd <= 1'b0;
            ovf          <= '0;
            any_ovf_o    <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
            rsp_err_o    <= 1'b0;
            for (int i = 0; i < int'(NUM_CNT); i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
        end else begin
            if (wr && ctrl_hit) {ctrl_snap_rd, ctrl_sat, ctrl_en} <= req_wdata_i[2:0];
            if (accept) begin
                rsp_valid_o <= 1'b1;
                rsp_data_o  <= req_we_i ? 64'd0 : rd_data;
                rsp_err_o   <= !(cnt_hit || ctrl_hit || ovf_hit);
            end else if (rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
            end
            any_ovf_o <= |ovf;
            // CLR beats preset beats counting; a fresh overflow beats W1C.
            for (int i = 0; i < int'(NUM_CNT); i++) begin
                if (snap_pulse) shadow[i] <= cnt[i];
                if (clr_pulse) begin
                    cnt[i] <= '0;
                    ovf[i] <= 1'b0;
                end else begin
                    if (preset[i]) begin
                        cnt[i] <= req_wdata_i[CNT_W-1:0];
                    end else if (ctrl_en && event_i[i]) begin
                        if (cnt[i] != CNT_MAX)  cnt[i] <= cnt[i] + 1'b1;
                        else if (!ctrl_sat)     cnt[i] <= '0;
                    end
                    if (ovf_set[i])      ovf[i] <= 1'b1;
                    else if (w1c_pad[i]) ovf[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pmu_counter_bank.sv
// Self-checking bench for pmu_counter_bank: directed scenarios plus random traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_pmu_counter_bank;
    localparam int NT   = 3;
    localparam int NE   = 23;
    localparam int CW   = 8;
    localparam int AW   = 12;
    localparam int NCNT = NT * NE;
    localparam int NOVF = (NCNT + 63) / 64;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NCNT-1:0] event_i = '0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic            req_we_i = 1'b0;
    logic [AW-1:0]   req_addr_i = '0;
    logic [63:0]     req_wdata_i = '0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic [63:0]     rsp_data_o;
    logic            rsp_err_o;
    logic            any_ovf_o;

    pmu_counter_bank #(.NUM_TILES(NT), .NUM_EVENTS(NE), .CNT_W(CW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .event_i(event_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .any_ovf_o(any_ovf_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    int          m_cnt [NCNT];
    int          m_sh  [NCNT];
    bit          m_ovf [NCNT];
    bit          m_en, m_sat, m_srd;
    bit          m_rv, m_re, m_any;
    logic [63:0] m_rd;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCNT; i++) begin
            m_cnt[i] = 0;
            m_sh[i]  = 0;
            m_ovf[i] = 1'b0;
        end
        {m_en, m_sat, m_srd, m_rv, m_re, m_any} = '0;
        m_rd = '0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        req_valid_i = 1'b0;
        event_i = '0;
        rsp_ready_i = 1'b0;
        @(posedge clk);
        #2;
        modelReset();
        checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        checkOutput("rst_rsp_data", rsp_data_o, 64'd0);
        checkOutput("rst_rsp_err", 64'(rsp_err_o), 64'd0);
        checkOutput("rst_any_ovf", 64'(any_ovf_o), 64'd0);
        checkOutput("rst_req_ready", 64'(req_ready_o), 64'd1);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, predict the edge, check the outcome.
    task automatic applyStimulus(input logic [NCNT-1:0] ev, input bit v, input bit we,
                                 input logic [AW-1:0] addr, input logic [63:0] wd, input bit rr);
        bit          rdy, acc, region, clr, snap, anyold, rerr;
        int          idx, j;
        logic [63:0] rdat;
        int          ncnt [NCNT];
        bit          novf [NCNT];
        bit          nov  [NCNT];

        event_i = ev; req_valid_i = v; req_we_i = we;
        req_addr_i = addr; req_wdata_i = wd; rsp_ready_i = rr;
        #1;
        rdy = !m_rv || rr;
        checkOutput("req_ready", 64'(req_ready_o), 64'(rdy));
        acc = v && rdy;
        region = addr[AW-1];
        idx = int'(addr[AW-2:0]);
        rdat = '0; rerr = 1'b0; clr = 1'b0; snap = 1'b0; anyold = 1'b0;
        ncnt = m_cnt;
        novf = m_ovf;
        for (int i = 0; i < NCNT; i++) begin
            anyold |= m_ovf[i];
            nov[i] = 1'b0;
            if (m_en && ev[i]) begin
                if (m_cnt[i] + 1 > CMAX) begin
                    nov[i]  = 1'b1;
                    novf[i] = 1'b1;
                    ncnt[i] = m_sat ? CMAX : 0;
                end else begin
                    ncnt[i] = m_cnt[i] + 1;
                end
            end
        end
        if (acc) begin
            if (!region) begin
                if (idx < NCNT) begin
                    rdat = 64'(m_srd ? m_sh[idx] : m_cnt[idx]);
                    if (we) begin
                        ncnt[idx] = int'(wd % 64'(CMAX + 1));
                        novf[idx] = m_ovf[idx];
                    end
                end else rerr = 1'b1;
            end else if (idx == 0) begin
                rdat[0] = m_en; rdat[1] = m_sat; rdat[2] = m_srd;
                if (we) begin
                    clr = wd[4];
                    snap = wd[3];
                end
            end else if (idx >= 1 && idx <= NOVF) begin
                for (int b = 0; b < 64; b++) begin
                    j = 64 * (idx - 1) + b;
                    if (j < NCNT) begin
                        rdat[b] = m_ovf[j];
                        if (we && wd[b] && !nov[j]) novf[j] = 1'b0;
                    end
                end
            end else rerr = 1'b1;
            if (we) rdat = '0;
        end
        if (clr) begin
            for (int i = 0; i < NCNT; i++) begin
                ncnt[i] = 0;
                novf[i] = 1'b0;
            end
        end

        @(posedge clk);
        #2;
        if (snap) m_sh = m_cnt;
        m_cnt = ncnt;
        m_ovf = novf;
        if (acc && we && region && idx == 0) begin
            m_en = wd[0]; m_sat = wd[1]; m_srd = wd[2];
        end
        if (acc) begin
            m_rv = 1'b1; m_rd = rdat; m_re = rerr;
        end else if (rr) m_rv = 1'b0;
        m_any = anyold;

        checkOutput("rsp_valid", 64'(rsp_valid_o), 64'(m_rv));
        if (m_rv) begin
            checkOutput("rsp_data", rsp_data_o, m_rd);
            checkOutput("rsp_err", 64'(rsp_err_o), 64'(m_re));
        end
        checkOutput("any_ovf", 64'(any_ovf_o), 64'(m_any));
    endtask

    localparam logic [AW-1:0] CTRL_A = 12'h800;
    localparam logic [AW-1:0] OVF1_A = 12'h801;

    initial begin
        logic [NCNT-1:0] e0, e2, e3, e5, eall, ev;
        logic [AW-1:0]   addr;
        logic [63:0]     wd;
        bit              v, we, rr;
        int              kind;

        e0 = '0; e0[0] = 1'b1;
        e2 = '0; e2[2] = 1'b1;
        e3 = '0; e3[3] = 1'b1;
        e5 = '0; e5[5] = 1'b1;
        eall = '1;

        doReset();

        // Basic counting of event bit 5
        applyStimulus('0, 1, 1, CTRL_A, 64'h1, 1);
        for (int n = 0; n < 10; n++) applyStimulus(e5, 0, 0, '0, '0, 1);
        applyStimulus('0, 1, 0, 12'h005, '0, 1);
        checkOutput("count10_data", rsp_data_o, 64'd10);
        checkOutput("count10_err", 64'(rsp_err_o), 64'd0);

        // Wrap mode overflow
        applyStimulus('0, 1, 1, 12'h000, 64'hFE, 1);
        for (int n = 0; n < 3; n++) applyStimulus(e0, 0, 0, '0, '0, 1);
        applyStimulus('0, 1, 0, 12'h000, '0, 1);
        checkOutput("wrap_value", rsp_data_o, 64'h01);
        applyStimulus('0, 1, 0, OVF1_A, '0, 1);
        checkOutput("wrap_ovf_word", rsp_data_o, 64'h1);
        checkOutput("wrap_any_ovf", 64'(any_ovf_o), 64'd1);

        // Saturate mode, then W1C
        applyStimulus('0, 1, 1, CTRL_A, 64'h3, 1);
        applyStimulus('0, 1, 1, 12'h000, 64'hFE, 1);
        for (int n = 0; n < 3; n++) applyStimulus(e0, 0, 0, '0, '0, 1);
        applyStimulus('0, 1, 0, 12'h000, '0, 1);
        checkOutput("sat_value", rsp_data_o, 64'hFF);
        applyStimulus('0, 1, 1, OVF1_A, 64'h1, 1);
        applyStimulus('0, 0, 0, '0, '0, 1);
        checkOutput("w1c_any_ovf", 64'(any_ovf_o), 64'd0);
        applyStimulus('0, 1, 0, OVF1_A, '0, 1);
        checkOutput("w1c_ovf_word", rsp_data_o, 64'h0);

        // Snapshot of counter 3 at value 7
        applyStimulus('0, 1, 1, CTRL_A, 64'h1, 1);
        applyStimulus(e3, 1, 1, 12'h003, 64'h0, 1);
        for (int n = 0; n < 7; n++) applyStimulus(e3, 0, 0, '0, '0, 1);
        applyStimulus(e3, 1, 1, CTRL_A, 64'h9, 1);
        applyStimulus(e3, 1, 1, CTRL_A, 64'h5, 1);
        applyStimulus(e3, 1, 0, 12'h003, '0, 1);
        checkOutput("snap_shadow", rsp_data_o, 64'd7);
        applyStimulus(e3, 1, 1, CTRL_A, 64'h1, 1);
        applyStimulus(e3, 1, 0, 12'h003, '0, 1);
        checkOutput("snap_live_gt7", 64'(rsp_data_o > 64'd7), 64'd1);

        // Preset beats event; CLR beats events, SNAP takes pre-clear values
        applyStimulus(e2, 1, 1, 12'h002, 64'h5A, 1);
        applyStimulus('0, 1, 0, 12'h002, '0, 1);
        checkOutput("preset_vs_event", rsp_data_o, 64'h5A);
        applyStimulus(eall, 1, 1, CTRL_A, 64'h19, 1);
        applyStimulus('0, 1, 1, CTRL_A, 64'h4, 1);
        applyStimulus('0, 1, 0, 12'h002, '0, 1);
        checkOutput("snapclr_shadow", rsp_data_o, 64'h5A);
        applyStimulus('0, 1, 1, CTRL_A, 64'h0, 1);
        applyStimulus('0, 1, 0, 12'h002, '0, 1);
        checkOutput("clr_live", rsp_data_o, 64'h0);

        // Error responses and backpressure
        applyStimulus('0, 1, 0, 12'(NCNT), '0, 1);
        checkOutput("err_cnt_range", 64'(rsp_err_o), 64'd1);
        checkOutput("err_cnt_data", rsp_data_o, 64'd0);
        applyStimulus('0, 1, 0, 12'hFFF, '0, 1);
        checkOutput("err_ctrl_range", 64'(rsp_err_o), 64'd1);
        for (int n = 0; n < 5; n++) begin
            applyStimulus('0, 1, 0, 12'h005, '0, 0);
            checkOutput("stall_hold_err", 64'(rsp_err_o), 64'd1);
            checkOutput("stall_ready_low", 64'(req_ready_o), 64'd0);
        end
        applyStimulus('0, 1, 0, 12'h005, '0, 1);
        checkOutput("stall_release_data", rsp_data_o, 64'd0);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            for (int b = 0; b < NCNT; b++) ev[b] = ($urandom_range(0, 2) == 0);
            v  = $urandom_range(0, 1) == 1;
            we = $urandom_range(0, 1) == 1;
            rr = $urandom_range(0, 3) != 0;
            kind = int'($urandom_range(0, 9));
            wd = {$urandom, $urandom};
            if (kind < 6) begin
                addr = {1'b0, 11'($urandom_range(0, NCNT + 1))};
                if ($urandom_range(0, 1) == 1) wd = 64'($urandom_range(8'hF0, 8'hFF));
            end else begin
                addr = {1'b1, 11'($urandom_range(0, NOVF + 1))};
                if (addr[AW-2:0] == '0) begin
                    wd = 64'($urandom_range(0, 15)) | 64'h1;
                    if ($urandom_range(0, 9) != 0) wd[4] = 1'b0;
                    if ($urandom_range(0, 3) == 0) wd[0] = 1'b0;
                end
            end
            applyStimulus(ev, v, we, addr, wd, rr);
        end

        // Reset with a pending response
        applyStimulus('0, 1, 1, 12'h001, 64'h77, 1);
        applyStimulus('0, 1, 0, 12'h001, '0, 0);
        doReset();
        applyStimulus('0, 1, 0, CTRL_A, '0, 1);
        checkOutput("post_rst_ctrl", rsp_data_o, 64'd0);
        applyStimulus('0, 1, 0, 12'h001, '0, 1);
        checkOutput("post_rst_cnt", rsp_data_o, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
